imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Writer side of the instruction memory that the single-cycle core fetches from.
// - Takes a length-prefixed byte stream over a valid/ready handshake and packs it
//   into 32-bit instruction words, one word per write.
// - Holds the core in reset (cpu_hold) until a load completes cleanly.
// PARAMETERS
// - ADDR_W      6   instruction memory word-address width; depth = 2**ADDR_W words
// - BIG_ENDIAN  1   1: first byte of each word -> wdata[31:24]; 0: first byte -> wdata[7:0]
// PORTS
// - clk         in   1       single clock, rising edge
// - reset       in   1       asynchronous, active-low
// - start       in   1       pulse; begins a load when IDLE or ERR
// - byte_valid  in   1       stream byte present
// - byte_data   in   8       stream byte
// - byte_ready  out  1       loader accepts byte_data this cycle
// - we          out  1       imem write strobe (registered, 1 cycle per word)
// - waddr       out  ADDR_W  imem word address
// - wdata       out  32      imem write data (instruction word)
// - cpu_hold    out  1       1 = core held in reset
// - done        out  1       1-cycle pulse on successful load
// - err         out  1       sticky load error
// BEHAVIOUR
// - Reset values: byte_ready=0, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, err=0, state=IDLE.
// - Handshake: a byte transfers on any edge with byte_valid & byte_ready.
//   - byte_ready=1 exactly in states LEN_HI, LEN_LO, DATA (and CHK).
//   - byte_ready never depends combinationally on byte_valid.
// - Stream format: count hi byte, count lo byte (16-bit word count N), then 4*N data bytes.
// - FSM:
//   - IDLE: start -> LEN_HI, cpu_hold=1. byte_valid is ignored.
//   - LEN_HI: on transfer, latch hi byte -> LEN_LO.
//   - LEN_LO: on transfer, form N:
//     - N==0 -> DONE (or CHK); no writes.
//     - N>2**ADDR_W -> ERR.
//     - Otherwise -> DATA, with word index=0 and byte index=0.
//   - DATA: shift each byte into the assembly register per BIG_ENDIAN.
//     - On the 4th byte: next cycle we=1, waddr=word index, wdata=assembled word.
//     - Word index then increments; byte index wraps 3->0.
//     - After the 4th byte of word N-1 -> DONE (or CHK).
//     - No back-pressure: byte_ready stays 1 throughout DATA.
//   - DONE: one cycle; done=1; cpu_hold deasserts on the same edge that raises done -> IDLE.
//   - ERR: err=1 (sticky), cpu_hold=1, byte_ready=0.
//     - Only start (clears err, -> LEN_HI) or reset leaves ERR.
// - While in LEN_HI, LEN_LO, DATA, CHK or DONE, start is ignored.
// - A reload from IDLE (start) re-asserts cpu_hold on the next edge.
// - The last word's we pulse and done fall in the same cycle or earlier; no we after done.
// - Reset mid-load aborts immediately to reset values.
//   - Words already written stay in imem; a partial word is discarded.
// - Counter widths:
//   - Word index is ADDR_W+1 bits, so N=2**ADDR_W fills memory without wrap.
//   - N is 16 bits unsigned.
// CONFIGURATION
// - IMEM_LOADER_CHECKSUM_EN defined:
//   - One extra byte follows the data: the XOR of all 4*N data bytes (0x00 when N==0).
//   - State CHK accepts it.
//   - Match -> DONE.
//   - Mismatch -> ERR (err=1, cpu_hold stays 1).
//   - Words already written are not rolled back.
// - Not defined: no CHK state; DATA/LEN_LO go directly to DONE.
// TESTING
// - Reset asserted with start=1, byte_valid=1 -> all outputs at reset values;
//   cpu_hold=1 throughout.
// - start, stream 00 02 AA BB CC DD 11 22 33 44, BIG_ENDIAN=1
//   -> we@0=0xAABBCCDD, we@1=0x11223344, done 1 cycle, cpu_hold 1->0.
// - Same stream with BIG_ENDIAN=0 and random byte_valid gaps
//   -> wdata 0xDDCCBBAA, 0x44332211; no extra/duplicate we.
// - Stream 00 00 -> done pulse, zero we pulses.
// - ADDR_W=6, stream 00 41 -> err=1, byte_ready=0, cpu_hold=1;
//   then start + 00 01 + 4 bytes -> err=0, done.
// - Reset after 5 data bytes of an N=2 load -> exactly one we seen, state IDLE;
//   start mid-DATA ignored.
// - CHECKSUM_EN: 00 01 01 02 04 08 0F -> done.
//   With last byte 0E -> err=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
// Bundles the two buses of the instruction-memory loader:
//   - byte stream: byte_valid / byte_data from the source, byte_ready back.
//     A byte transfers on every rising edge where byte_valid & byte_ready are
//     both 1. byte_ready never depends on byte_valid.
//   - imem write port: we / waddr / wdata, driven by the loader.
// Modports:
//   master : stream source / memory side (drives byte_valid, byte_data)
//   slave  : the loader (drives byte_ready, we, waddr, wdata)
// Parameter ADDR_W must match the loader's ADDR_W.
// ----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Writer side of the single-cycle core's instruction memory. Receives a
// length-prefixed byte stream (count hi, count lo, then 4*N data bytes),
// packs it into 32-bit words and writes one word per we pulse. The core is
// held in reset (cpu_hold=1) until a load finishes cleanly.
//
// Parameters:
//   ADDR_W     : imem word-address width, depth = 2**ADDR_W words
//   BIG_ENDIAN : 1 -> first byte of a word lands in wdata[31:24],
//                0 -> first byte lands in wdata[7:0]
// Optional feature macro IMEM_LOADER_CHECKSUM_EN:
//   one extra byte (XOR of all data bytes) follows the data and is checked
//   in state CHK; a mismatch goes to ERR.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low
//   start     : pulse, starts a load from IDLE or ERR
//   bus       : imem_loader_if.slave (byte stream in, imem write port out)
//   cpu_hold  : 1 = core held in reset
//   done      : 1-cycle pulse on a successful load
//   err       : sticky load error, cleared by start or reset
//   state_dbg : current FSM state (IDLE=0, LEN_HI=1, LEN_LO=2, DATA=3,
//               CHK=4, DONE=5, ERR=6)
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W     = 6,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t            state;
    state_t            state_next;
    logic [7:0]        len_hi;
    logic [15:0]       n_words;
    // One bit wider than the address so a full-depth load never wraps.
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       asm_word;
    logic [31:0]       asm_next;
    logic [15:0]       n_new;
    logic              xfer;
    logic              last_byte;
    logic              last_word;
    logic              too_big;
    logic              start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign state_dbg      = state;
    // Ready is a pure function of state, never of byte_valid.
    assign bus.byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                            (state == S_DATA)   || (state == S_CHK);
    assign xfer      = bus.byte_valid & bus.byte_ready;
    assign n_new     = {len_hi, bus.byte_data};
    assign too_big   = {16'd0, n_new} > DEPTH;
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (32'(word_idx) + 32'd1) == {16'd0, n_words};
    assign start_ok  = start && ((state == S_IDLE) || (state == S_ERR));

    always_comb begin
        asm_next = {asm_word[23:0], bus.byte_data};
        if (!BIG_ENDIAN) begin
            asm_next = {bus.byte_data, asm_word[31:8]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (n_new == 16'd0) state_next = S_FINISH;
                    else if (too_big)   state_next = S_ERR;
                    else                state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && last_byte && last_word) state_next = S_FINISH;
            end
            S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) state_next = (bus.byte_data == csum) ? S_DONE : S_ERR;
`else
                state_next = S_DONE;
`endif
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            S_ERR: begin
                if (start) state_next = S_LEN_HI;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi    <= 8'd0;
            n_words   <= 16'd0;
            word_idx  <= '0;
            byte_idx  <= 2'd0;
            asm_word  <= 32'd0;
            bus.we    <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= 32'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            bus.we <= 1'b0;
            if (start_ok) begin
                word_idx <= '0;
                byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end
            if ((state == S_LEN_HI) && xfer) begin
                len_hi <= bus.byte_data;
            end
            if ((state == S_LEN_LO) && xfer) begin
                n_words  <= n_new;
                word_idx <= '0;
                byte_idx <= 2'd0;
            end
            if ((state == S_DATA) && xfer) begin
                asm_word <= asm_next;
                byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum ^ bus.byte_data;
`endif
                // Fourth byte completes the word: write it on the next cycle.
                if (last_byte) begin
                    bus.we    <= 1'b1;
                    bus.waddr <= word_idx[ADDR_W-1:0];
                    bus.wdata <= asm_next;
                    word_idx  <= word_idx + 1'b1;
                end
            end
            // done/err follow the state being entered so they line up with
            // the last word's we and with the ERR state itself.
            done <= (state_next == S_DONE);
            err  <= (state_next == S_ERR);
            if (state_next == S_DONE) begin
                cpu_hold <= 1'b0;
            end else if (start_ok) begin
                cpu_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic       cpu_hold_be, done_be, err_be;
    logic       cpu_hold_le, done_le, err_le;
    logic [2:0] state_be, state_le;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus_be ();
    imem_loader_if #(.ADDR_W(ADDR_W)) bus_le ();

    imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) u_be (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus_be),
        .cpu_hold  (cpu_hold_be),
        .done      (done_be),
        .err       (err_be),
        .state_dbg (state_be)
    );

    imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) u_le (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus_le),
        .cpu_hold  (cpu_hold_le),
        .done      (done_le),
        .err       (err_le),
        .state_dbg (state_le)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int done_cnt_be = 0;
    int done_cnt_le = 0;
    logic [ADDR_W+31:0] exp_be_q[$];
    logic [ADDR_W+31:0] exp_le_q[$];
    logic [7:0]         data_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every we must match the next expected word, and
    // by the cycle done rises every expected word must already be written.
    always @(negedge clk) begin
        if (bus_be.we) begin
            if (exp_be_q.size() == 0) check("we_be_unexpected", bus_be.we, 1'b0);
            else check("we_be", {bus_be.waddr, bus_be.wdata}, exp_be_q.pop_front());
        end
        if (bus_le.we) begin
            if (exp_le_q.size() == 0) check("we_le_unexpected", bus_le.we, 1'b0);
            else check("we_le", {bus_le.waddr, bus_le.wdata}, exp_le_q.pop_front());
        end
        if (done_be) begin
            done_cnt_be++;
            check("we_before_done_be", exp_be_q.size(), 0);
        end
        if (done_le) begin
            done_cnt_le++;
            check("we_before_done_le", exp_le_q.size(), 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_bus(input logic v, input logic [7:0] d);
        bus_be.byte_valid = v;
        bus_le.byte_valid = v;
        bus_be.byte_data  = d;
        bus_le.byte_data  = d;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte after 0..max_gap idle cycles; returns at the negedge
    // before the posedge on which it transfers.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int budget;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) begin
            @(negedge clk);
            set_bus(1'b0, 8'($urandom));
        end
        @(negedge clk);
        set_bus(1'b1, b);
        budget = 0;
        while (!bus_be.byte_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) check("ready_timeout", bus_be.byte_ready, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, bus_be.byte_ready, 1'b0);
        check({tag, "_we"},    bus_be.we,         1'b0);
        check({tag, "_waddr"}, bus_be.waddr,      '0);
        check({tag, "_wdata"}, bus_be.wdata,      32'd0);
        check({tag, "_hold"},  cpu_hold_be,       1'b1);
        check({tag, "_done"},  done_be,           1'b0);
        check({tag, "_err"},   err_be,            1'b0);
        check({tag, "_state"}, state_be,          3'd0);
        check({tag, "_hold_le"}, cpu_hold_le,     1'b1);
        check({tag, "_we_le"},   bus_le.we,       1'b0);
    endtask

    // Reference model of one load: length prefix, then N words taken from
    // data_q (random when data_q runs out). A length above the memory depth
    // ends in ERR right after the count; with the checksum build the XOR of
    // the data bytes (optionally corrupted) follows the data.
    task automatic load(input logic [15:0] n, input int max_gap, input logic [7:0] csum_flip);
        int   before_be;
        int   before_le;
        bit   expect_done;
        logic [7:0] x;
        logic [7:0] b [4];
        before_be   = done_cnt_be;
        before_le   = done_cnt_le;
        expect_done = (int'(n) <= DEPTH);
        x = 8'd0;
        pulse_start();
        #1;
        check("hold_at_start", cpu_hold_be, 1'b1);
        check("err_cleared_at_start", err_be, 1'b0);
        send_byte(n[15:8], max_gap);
        send_byte(n[7:0], max_gap);
        if (expect_done) begin
            for (int w = 0; w < int'(n); w++) begin
                for (int k = 0; k < 4; k++) begin
                    b[k] = (data_q.size() > 0) ? data_q.pop_front() : 8'($urandom);
                    x = x ^ b[k];
                end
                exp_be_q.push_back({w[ADDR_W-1:0], b[0], b[1], b[2], b[3]});
                exp_le_q.push_back({w[ADDR_W-1:0], b[3], b[2], b[1], b[0]});
                for (int k = 0; k < 4; k++) send_byte(b[k], max_gap);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(x ^ csum_flip, max_gap);
            if (csum_flip != 8'd0) expect_done = 1'b0;
`else
            x = x ^ csum_flip;
`endif
        end
        @(negedge clk);
        set_bus(1'b0, 8'($urandom));
        for (int c = 0; c < 8; c++) begin
            #1;
            if (done_cnt_be != before_be || err_be) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        #1;
        if (expect_done) begin
            check("done_pulses_be", done_cnt_be - before_be, 1);
            check("done_pulses_le", done_cnt_le - before_le, 1);
            check("err_after_ok",   err_be,      1'b0);
            check("hold_released",  cpu_hold_be, 1'b0);
            check("hold_released_le", cpu_hold_le, 1'b0);
        end else begin
            check("done_pulses_err", done_cnt_be - before_be, 0);
            check("err_set",         err_be,             1'b1);
            check("err_ready_low",   bus_be.byte_ready,  1'b0);
            check("err_hold",        cpu_hold_be,        1'b1);
        end
        check("pending_we_be", exp_be_q.size(), 0);
        check("pending_we_le", exp_le_q.size(), 0);
        data_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b5 [5];
        logic [15:0] n;
        set_bus(1'b0, 8'd0);

        // Reset asserted with start and byte_valid high.
        #2;
        reset = 1'b0;
        start = 1'b1;
        set_bus(1'b1, 8'h5A);
        repeat (3) begin
            @(negedge clk);
            check("hold_in_reset", cpu_hold_be, 1'b1);
        end
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;

        // IDLE ignores byte_valid.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("idle_ready", bus_be.byte_ready, 1'b0);
            check("idle_state", state_be, 3'd0);
        end
        set_bus(1'b0, 8'd0);

        // Directed stream, no gaps, then the same with random gaps.
        for (int pass = 0; pass < 2; pass++) begin
            data_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
            load(16'd2, pass * 3, 8'd0);
        end

        // Empty load.
        load(16'd0, 0, 8'd0);

        // Over-long count, then recovery with a one-word load.
        load(16'd65, 0, 8'd0);
        load(16'd1, 1, 8'd0);

        // Exactly full memory.
        load(16'(DEPTH), 0, 8'd0);

        // Reset after 5 data bytes of an N=2 load; start mid-DATA ignored.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int k = 0; k < 5; k++) b5[k] = 8'($urandom);
        exp_be_q.push_back({6'd0, b5[0], b5[1], b5[2], b5[3]});
        exp_le_q.push_back({6'd0, b5[3], b5[2], b5[1], b5[0]});
        send_byte(b5[0], 0);
        send_byte(b5[1], 0);
        start = 1'b1;
        send_byte(b5[2], 0);
        start = 1'b0;
        send_byte(b5[3], 0);
        send_byte(b5[4], 0);
        @(negedge clk);
        set_bus(1'b0, 8'd0);
        #1;
        check("midload_one_we_be", exp_be_q.size(), 0);
        check("midload_one_we_le", exp_le_q.size(), 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("midrst");
        reset = 1'b1;

        // Randomized loads: mostly short, occasionally an over-long count.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 4) == 0) n = 16'($urandom_range(DEPTH + 1, 65535));
            else n = 16'($urandom_range(0, 6));
            load(n, int'($urandom_range(0, 3)), 8'd0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        data_q = '{8'h01, 8'h02, 8'h04, 8'h08};
        load(16'd1, 0, 8'd0);
        data_q = '{8'h01, 8'h02, 8'h04, 8'h08};
        load(16'd1, 0, 8'h01);
        load(16'd2, 2, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
